// File: rtl/data_importer_if.sv
// PMOD loader bus: raw host pins in, record-RAM write port and status out.
interface data_importer_if #(
  parameter int ADDR_WIDTH = 11
);
  logic [7:0]            pmod;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;
  logic                  loading;
  logic                  done;
  logic                  frame_err;

  // Host / bench side: drives the pins, observes the RAM port and status.
  modport master (
    output pmod,
    input  wr_en, wr_addr, wr_data, loading, done, frame_err
  );

  // Importer side.
  modport slave (
    input  pmod,
    output wr_en, wr_addr, wr_data, loading, done, frame_err
  );
endinterface

// File: rtl/data_importer.sv
// Host-to-FPGA loader: synchronises the PMOD pins, turns STB toggles into
// nibble events, assembles 8 nibbles (MSB first) into a 32-bit claim record
// and writes DEPTH records sequentially into the record RAM.
module data_importer #(
  parameter int DEPTH      = 1237,
  parameter int ADDR_WIDTH = 11
) (
  input  logic              clk,
  input  logic              reset,
  data_importer_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  // Synchroniser chain. The reserved pins [5:4] carry no meaning and are not
  // brought into the clock domain; the chain holds {STB, SOF, nibble}.
  logic [5:0] r_s1;
  logic [5:0] r_s2;
  logic       r_s3;

  logic [2:0]            r_cnt,   w_cnt;
  logic [ADDR_WIDTH-1:0] r_idx,   w_idx;
  logic [31:0]           r_shift, w_shift;
  state_t                r_state, w_state;

  logic                  r_wr_en,     w_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr,   w_wr_addr;
  logic [31:0]           r_wr_data,   w_wr_data;
  logic                  r_frame_err, w_frame_err;
  logic                  r_loading;
  logic                  r_done;

  logic       w_event;
  logic       w_sof;
  logic [3:0] w_nib;
  logic [31:0] w_shifted;
  logic       w_start;

  // An event is a change of the synchronised STB against its previous value.
  assign w_event   = r_s2[5] ^ r_s3;
  assign w_sof     = r_s2[4];
  assign w_nib     = r_s2[3:0];
  assign w_shifted = {r_shift[27:0], w_nib};

  // Next-state, assembly and write-port decode.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_idx       = r_idx;
    w_shift     = r_shift;
    w_wr_en     = 1'b0;
    w_wr_addr   = r_wr_addr;
    w_wr_data   = r_wr_data;
    w_frame_err = r_frame_err;
    w_start     = 1'b0;

    if (w_event) begin
      unique case (r_state)
        S_IDLE: w_start = w_sof;
        S_LOAD: begin
          if (w_sof) begin
            // A fresh SOF with anything already collected is a broken frame.
            if (r_cnt != 3'd0 || r_idx != '0) w_frame_err = 1'b1;
            w_start = 1'b1;
          end else begin
            w_shift = w_shifted;
            w_cnt   = r_cnt + 3'd1;  // the 8th nibble wraps the count to 0
            if (r_cnt == 3'd7) begin
              w_wr_en   = 1'b1;
              w_wr_addr = r_idx;
              w_wr_data = w_shifted;
              if (r_idx == LAST_IDX) w_state = S_DONE;
              else                   w_idx   = r_idx + ADDR_WIDTH'(1);
            end
          end
        end
        S_DONE: w_start = w_sof;
        default: w_state = S_IDLE;
      endcase
    end

    // Any accepted SOF begins a new frame with this nibble as its first.
    if (w_start) begin
      w_state = S_LOAD;
      w_shift = {28'd0, w_nib};
      w_cnt   = 3'd1;
      w_idx   = '0;
    end
  end

  // State, synchroniser and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      r_s1        <= '0;
      r_s2        <= '0;
      r_s3        <= 1'b0;
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_frame_err <= 1'b0;
      r_loading   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_s1        <= {bus.pmod[7:6], bus.pmod[3:0]};
      r_s2        <= r_s1;
      r_s3        <= r_s2[5];
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_idx       <= w_idx;
      r_shift     <= w_shift;
      r_wr_en     <= w_wr_en;
      r_wr_addr   <= w_wr_addr;
      r_wr_data   <= w_wr_data;
      r_frame_err <= w_frame_err;
      // Status follows the state one edge later, so done rises the edge after
      // the final write strobe and loading falls on that same edge.
      r_loading   <= (r_state == S_LOAD);
      r_done      <= (r_state == S_DONE);
    end
  end

  assign bus.wr_en     = r_wr_en;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_wr_data;
  assign bus.loading   = r_loading;
  assign bus.done      = r_done;
  assign bus.frame_err = r_frame_err;

endmodule

// File: tb/tb_data_importer.sv
// Scoreboard bench for data_importer: stimulus drives PMOD nibbles and a
// frame-level model pushes expected RAM writes; a monitor pops and compares.
module tb_data_importer;

  localparam int DEPTH = 2;
  localparam int AW    = 11;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_importer_if #(.ADDR_WIDTH(AW)) bus ();

  data_importer #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    bit            last;
  } wr_t;

  int  checks = 0;
  int  errors = 0;
  wr_t exp_q[$];

  // Frame-level reference model.
  bit         m_active;
  bit         m_done;
  bit         m_err;
  logic [3:0] m_nibs[$];
  logic       stb;
  bit         done_next;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0;
    m_done   = 0;
    m_err    = 0;
    m_nibs.delete();
  endtask

  // A frame is the list of nibbles since its SOF; every 8th nibble completes
  // record (n/8 - 1), and DEPTH records end the frame.
  task automatic model_event(input logic [3:0] nib, input bit sof);
    logic [31:0] rec;
    wr_t w;
    if (sof) begin
      if (m_active && m_nibs.size() > 0) m_err = 1;
      m_nibs.delete();
      m_nibs.push_back(nib);
      m_active = 1;
      m_done   = 0;
    end else if (m_active) begin
      m_nibs.push_back(nib);
      if (m_nibs.size() % 8 == 0) begin
        rec = 0;
        for (int i = m_nibs.size() - 8; i < m_nibs.size(); i++) rec = rec * 16 + 32'(m_nibs[i]);
        w.addr = AW'(m_nibs.size() / 8 - 1);
        w.data = rec;
        w.last = (m_nibs.size() == 8 * DEPTH);
        exp_q.push_back(w);
        if (w.last) begin
          m_active = 0;
          m_done   = 1;
        end
      end
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, ".loading"},   64'(bus.loading),   64'(m_active));
    check({tag, ".done"},      64'(bus.done),      64'(m_done));
    check({tag, ".frame_err"}, 64'(bus.frame_err), 64'(m_err));
  endtask

  // One nibble: toggle STB with SOF/nibble, random reserved bits, then hold.
  task automatic send(input logic [3:0] nib, input bit sof, input bit chk);
    @(negedge clk);
    stb = ~stb;
    bus.pmod = {stb, sof, 2'($urandom_range(0, 3)), nib};
    model_event(nib, sof);
    repeat (6) @(negedge clk);
    if (chk) check_status("nib");
  endtask

  task automatic send_word(input logic [31:0] w, input bit sof_first);
    for (int i = 7; i >= 0; i--) send(w[4*i +: 4], sof_first && i == 7, 1'b0);
    check_status("word");
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    exp_q.delete();
    done_next = 0;
    for (int i = 0; i < 3; i++) begin
      stb = ~stb;
      bus.pmod = {stb, 1'b1, 2'b00, 4'(i + 5)};
      @(negedge clk);
    end
    stb = 1'b0;
    bus.pmod = 8'h00;
    @(negedge clk);
    check("rst.wr_en",     64'(bus.wr_en),     64'd0);
    check("rst.wr_addr",   64'(bus.wr_addr),   64'd0);
    check("rst.wr_data",   64'(bus.wr_data),   64'd0);
    check_status("rst");
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    wr_t e;
    if (done_next) begin
      check("done_rise", 64'(bus.done), 64'd1);
      check("loading_fall", 64'(bus.loading), 64'd0);
      done_next = 0;
    end
    if (bus.wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_write: got addr %0h data %0h expected no write", bus.wr_addr, bus.wr_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(bus.wr_addr), 64'(e.addr));
        check("wr_data", 64'(bus.wr_data), 64'(e.data));
        if (e.last) begin
          check("done_before", 64'(bus.done), 64'd0);
          done_next = 1;
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    stb = 1'b0;
    bus.pmod = 8'h00;
    done_next = 0;
    model_reset();
    repeat (2) @(negedge clk);

    // Reset with STB toggling.
    do_reset();

    // Single record, then the second record completes the frame.
    send_word(32'h01234567, 1'b1);
    check("single.loading", 64'(bus.loading), 64'd1);
    send_word(32'h89ABCDEF, 1'b0);
    check("full.done", 64'(bus.done), 64'd1);
    for (int i = 0; i < 3; i++) send(4'(i), 1'b0, 1'b1);

    // Reload after DONE: clean, no frame error.
    send_word(32'hCAFEF00D, 1'b1);
    check("reload.done_low", 64'(bus.done), 64'd0);
    send_word(32'h12345678, 1'b0);
    check("reload.err_low", 64'(bus.frame_err), 64'd0);

    // Mid-record restart.
    do_reset();
    send(4'h3, 1'b1, 1'b1);
    send(4'h4, 1'b0, 1'b1);
    send(4'h5, 1'b0, 1'b1);
    send_word(32'hFEDCBA98, 1'b1);
    check("restart.err", 64'(bus.frame_err), 64'd1);

    // Reset mid-load, then a clean record.
    do_reset();
    send(4'h9, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send(4'hA, 1'b0, 1'b0);
    do_reset();
    send_word(32'h0BADBEEF, 1'b1);

    // Randomised traffic: occasional SOF, random nibbles.
    do_reset();
    for (int i = 0; i < 150; i++)
      send(4'($urandom_range(0, 15)), ($urandom_range(0, 19) == 0), 1'b1);

    repeat (8) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
